// File: rtl/w5300_reg_access.sv
// Register-access sequencer for the W5300 parallel bus stage: splits 16/32-bit
// register requests into 16-bit bus cycles and returns read data and an error flag.
module w5300_reg_access #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_wide,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [10:0] bus_caddr,
  output logic [15:0] bus_wr_data,
  output logic        bus_start,
  input  logic        bus_ready,
  input  logic [15:0] bus_rd_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t          state_reg;
  logic            wr_reg;
  logic            wide_reg;
  logic            word_reg;
  logic [9:0]      addr_reg;
  logic [15:0]     wlo_reg;
  logic [15:0]     hi_reg;
  logic [CW-1:0]   wd_cnt_reg;
  logic [9:0]      addr_next;

  assign addr_next = addr_reg + 10'd2;

  // wd_cnt_reg counts cycles since ISSUE, so a stalled word aborts with
  // rsp_valid exactly TIMEOUT_CYCLES cycles after its bus_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0;
      bus_start   <= 1'b0;
      bus_caddr   <= 11'h400;
      bus_wr_data <= 16'h0;
      wr_reg      <= 1'b0;
      wide_reg    <= 1'b0;
      word_reg    <= 1'b0;
      addr_reg    <= 10'h0;
      wlo_reg     <= 16'h0;
      hi_reg      <= 16'h0;
      wd_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wr_reg    <= req_wr;
            wide_reg  <= req_wide;
            addr_reg  <= req_addr;
            wlo_reg   <= req_wdata[15:0];
            word_reg  <= 1'b0;
            if (req_wide && req_addr[0]) begin
              state_reg <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state_reg   <= S_ISSUE;
              bus_start   <= 1'b1;
              bus_caddr   <= {~req_wr, req_addr};
              bus_wr_data <= req_wide ? req_wdata[31:16] : req_wdata[15:0];
              wd_cnt_reg  <= '0;
            end
          end
        end

        S_ISSUE: begin
          bus_start  <= 1'b0;
          wd_cnt_reg <= wd_cnt_reg + CW'(1);
          state_reg  <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          wd_cnt_reg <= wd_cnt_reg + CW'(1);
          if (wd_cnt_reg == CNT_LAST) begin
            state_reg <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else if (!bus_ready) begin
            state_reg <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          wd_cnt_reg <= wd_cnt_reg + CW'(1);
          // A word that completes on the last allowed cycle still counts as done.
          if (bus_ready) begin
            if (wide_reg && !word_reg) begin
              word_reg    <= 1'b1;
              hi_reg      <= bus_rd_data;
              addr_reg    <= addr_next;
              bus_caddr   <= {~wr_reg, addr_next};
              bus_wr_data <= wlo_reg;
              bus_start   <= 1'b1;
              wd_cnt_reg  <= '0;
              state_reg   <= S_ISSUE;
            end else begin
              state_reg <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              if (wr_reg)
                rsp_rdata <= 32'h0;
              else if (wide_reg)
                rsp_rdata <= {hi_reg, bus_rd_data};
              else
                rsp_rdata <= {16'h0, bus_rd_data};
            end
          end else if (wd_cnt_reg == CNT_LAST) begin
            state_reg <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end
        end

        S_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          bus_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_reg_access.sv
// Directed bench for w5300_reg_access: table of register transactions against a
// behavioural bus stage, plus timeout and mid-transaction reset sequences.
module tb_w5300_reg_access;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_wide;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [10:0] bus_caddr;
  logic [15:0] bus_wr_data;
  logic        bus_start;
  logic        bus_ready;
  logic [15:0] bus_rd_data;

  always #5 clk = ~clk;

  w5300_reg_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_caddr(bus_caddr), .bus_wr_data(bus_wr_data), .bus_start(bus_start),
    .bus_ready(bus_ready), .bus_rd_data(bus_rd_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Bus stage model: mode 0 normal, 1 never goes busy, 2 goes busy and sticks.
  logic [15:0] mem [0:1023];
  int          bus_mode = 0;
  int          busy_cfg = 1;
  int          busy_left = 0;
  int          start_cnt = 0;
  logic [10:0] log_caddr [$];
  logic [15:0] log_wd [$];

  initial begin
    bus_ready   = 1'b1;
    bus_rd_data = 16'h0;
    forever begin
      @(negedge clk);
      if (bus_start) begin
        start_cnt++;
        log_caddr.push_back(bus_caddr);
        log_wd.push_back(bus_wr_data);
        if (bus_caddr[10]) bus_rd_data = mem[bus_caddr[9:0]];
        else               mem[bus_caddr[9:0]] = bus_wr_data;
        if (bus_mode != 1) begin
          bus_ready = 1'b0;
          busy_left = busy_cfg;
        end
      end else if (!bus_ready && bus_mode == 0) begin
        if (busy_left == 0) bus_ready = 1'b1;
        else busy_left--;
      end
    end
  end

  int rsp_cnt = 0;
  int overlap_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
      if (rsp_valid && req_ready) overlap_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present(input bit wr, input bit wide, input logic [9:0] addr,
                         input logic [31:0] wdata, output int acc_cyc, output bit ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_wide = wide; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp(output int rsp_cyc, output logic [31:0] rd,
                          output logic err, output bit ok);
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = rsp_valid;
    rsp_cyc = cyc;
    rd = rsp_rdata;
    err = rsp_err;
  endtask

  typedef struct {
    bit          wr;
    bit          wide;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          busy;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_starts;
    logic [10:0] c0;
    logic [15:0] d0;
    logic [10:0] c1;
    logic [15:0] d1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int acc, rc, s0, exp_rsp, lat;
    bit ok_a, ok_r;
    logic [31:0] rd;
    logic e;

    vecs[0] = '{0, 0, 10'h204, 32'h0,        2, 32'h0000A5C3, 0, 1, 11'h604, 16'h0,    11'h0,   16'h0};
    vecs[1] = '{1, 1, 10'h020, 32'h12345678, 1, 32'h0,        0, 2, 11'h020, 16'h1234, 11'h022, 16'h5678};
    vecs[2] = '{0, 1, 10'h3FE, 32'h0,        1, 32'hBEEFCAFE, 0, 2, 11'h7FE, 16'h0,    11'h400, 16'h0};
    vecs[3] = '{0, 1, 10'h021, 32'h0,        1, 32'h0,        1, 0, 11'h0,   16'h0,    11'h0,   16'h0};
    vecs[4] = '{0, 1, 10'h020, 32'h0,        3, 32'h12345678, 0, 2, 11'h420, 16'h0,    11'h422, 16'h0};
    vecs[5] = '{1, 0, 10'h100, 32'hFFFF9ABC, 1, 32'h0,        0, 1, 11'h100, 16'h9ABC, 11'h0,   16'h0};
    vecs[6] = '{0, 0, 10'h100, 32'h0,        1, 32'h00009ABC, 0, 1, 11'h500, 16'h0,    11'h0,   16'h0};
    vecs[7] = '{0, 0, 10'h105, 32'h0,        1, 32'h00001111, 0, 1, 11'h505, 16'h0,    11'h0,   16'h0};
    vecs[8] = '{1, 1, 10'h033, 32'hDEADBEEF, 1, 32'h0,        1, 0, 11'h0,   16'h0,    11'h0,   16'h0};

    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[10'h204] = 16'hA5C3;
    mem[10'h3FE] = 16'hBEEF;
    mem[10'h000] = 16'hCAFE;
    mem[10'h105] = 16'h1111;
    exp_rsp = 0;

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_wide = 1'b0;
    req_addr = 10'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset bus_start", 32'(bus_start), 32'd0);
    chk("reset bus_caddr", 32'(bus_caddr), 32'h400);
    chk("reset bus_wr_data", 32'(bus_wr_data), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      bus_mode = 0;
      busy_cfg = vecs[i].busy;
      s0 = start_cnt;
      log_caddr.delete();
      log_wd.delete();
      present(vecs[i].wr, vecs[i].wide, vecs[i].addr, vecs[i].wdata, acc, ok_a);
      wait_rsp(rc, rd, e, ok_r);
      exp_rsp++;
      lat = vecs[i].exp_starts * (vecs[i].busy + 2);
      chk($sformatf("v%0d accepted", i), 32'(ok_a), 32'd1);
      chk($sformatf("v%0d rsp seen", i), 32'(ok_r), 32'd1);
      chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d latency", i), 32'(rc - acc), 32'(lat));
      @(negedge clk);
      chk($sformatf("v%0d bus starts", i), 32'(start_cnt - s0), 32'(vecs[i].exp_starts));
      chk($sformatf("v%0d ready after", i), 32'(req_ready), 32'd1);
      if (log_caddr.size() > 0) begin
        chk($sformatf("v%0d caddr0", i), 32'(log_caddr[0]), 32'(vecs[i].c0));
        if (vecs[i].wr) chk($sformatf("v%0d wdata0", i), 32'(log_wd[0]), 32'(vecs[i].d0));
      end
      if (log_caddr.size() > 1) begin
        chk($sformatf("v%0d caddr1", i), 32'(log_caddr[1]), 32'(vecs[i].c1));
        if (vecs[i].wr) chk($sformatf("v%0d wdata1", i), 32'(log_wd[1]), 32'(vecs[i].d1));
      end
      $display("vec %0d wr=%0b wide=%0b addr=%h rdata=%h err=%0b lat=%0d", i,
               vecs[i].wr, vecs[i].wide, vecs[i].addr, rd, e, rc - acc);
    end

    // Bus never acknowledges the start: abort after TO cycles, word 1 never issued.
    bus_mode = 1;
    s0 = start_cnt;
    log_caddr.delete();
    log_wd.delete();
    present(1'b0, 1'b1, 10'h200, 32'h0, acc, ok_a);
    wait_rsp(rc, rd, e, ok_r);
    exp_rsp++;
    chk("to1 rsp seen", 32'(ok_r), 32'd1);
    chk("to1 err", 32'(e), 32'd1);
    chk("to1 rdata", rd, 32'h0);
    chk("to1 latency", 32'(rc - acc), 32'(TO));
    repeat (4) @(negedge clk);
    chk("to1 bus starts", 32'(start_cnt - s0), 32'd1);
    if (log_caddr.size() > 0) chk("to1 caddr0", 32'(log_caddr[0]), 32'h600);
    $display("timeout ready-high: err=%0b lat=%0d", e, rc - acc);

    // Bus goes busy and never finishes: abort from WAIT_DONE.
    bus_mode = 2;
    s0 = start_cnt;
    present(1'b1, 1'b1, 10'h300, 32'h0BAD0F00, acc, ok_a);
    wait_rsp(rc, rd, e, ok_r);
    exp_rsp++;
    chk("to2 rsp seen", 32'(ok_r), 32'd1);
    chk("to2 err", 32'(e), 32'd1);
    chk("to2 latency", 32'(rc - acc), 32'(TO));
    repeat (3) @(negedge clk);
    chk("to2 bus starts", 32'(start_cnt - s0), 32'd1);
    $display("timeout stuck-busy: err=%0b lat=%0d", e, rc - acc);
    bus_mode = 0;
    bus_ready = 1'b1;
    busy_left = 0;

    // Reset pulsed while the first word of a wide write is in WAIT_DONE.
    busy_cfg = 6;
    present(1'b1, 1'b1, 10'h040, 32'hAAAA5555, acc, ok_a);
    repeat (3) @(negedge clk);
    s0 = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_ready = 1'b1;
    busy_left = 0;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst bus_start", 32'(bus_start), 32'd0);
    chk("rst bus_caddr", 32'(bus_caddr), 32'h400);
    chk("rst bus_wr_data", 32'(bus_wr_data), 32'h0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    repeat (8) @(negedge clk);
    chk("rst no rsp", 32'(rsp_cnt - s0), 32'd0);
    $display("reset mid-write: ready=%0b caddr=%h", req_ready, bus_caddr);

    busy_cfg = 2;
    present(1'b0, 1'b0, 10'h204, 32'h0, acc, ok_a);
    wait_rsp(rc, rd, e, ok_r);
    exp_rsp++;
    chk("post-rst rdata", rd, 32'h0000A5C3);
    chk("post-rst err", 32'(e), 32'd0);
    chk("post-rst latency", 32'(rc - acc), 32'd4);
    $display("post-reset read: rdata=%h err=%0b", rd, e);

    repeat (3) @(negedge clk);
    chk("total rsp count", 32'(rsp_cnt), 32'(exp_rsp));
    chk("rsp/ready overlap", 32'(overlap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
